ebpc_znz_decoder: RTL and testbench
===================================

Name: ebpc_znz_decoder

Overview:
- Decodes the packed zero/non-zero (ZNZ) run-length stream of the EBPC scheme.
- Merges the decoded stream with the already-decoded non-zero values from the BPC decode path.
- Rebuilds the original element stream with last marking.
- Sits after the stream splitter and beside the BPC decoder inside the EBPC decode path; bit-serial over the ZNZ symbol stream.

Parameters:
DATA_W, 8, width of ZNZ packed words, BPC values and output data
MAX_ZERO_RUN, 16, longest zero run per symbol; ZRL_W = $clog2(MAX_ZERO_RUN) (derived localparam)
CNT_W, 16, width of element-count configuration

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
cfg_num_i  in  CNT_W  number of elements in the next stream
cfg_vld_i / cfg_rdy_o  in/out  1  config handshake
znz_data_i  in  DATA_W  packed ZNZ word, MSB-first
znz_last_i  in  1  marks final ZNZ word of the stream
znz_vld_i / znz_rdy_o  in/out  1  ZNZ handshake
bpc_data_i  in  DATA_W  decoded non-zero value
bpc_vld_i / bpc_rdy_o  in/out  1  BPC value handshake
data_o  out  DATA_W  reconstructed element
last_o  out  1  final element of the stream
vld_o / rdy_i  out/in  1  output handshake
idle_o  out  1  IDLE state and word buffer empty
err_o  out  1  sticky stream-format error, cleared on next cfg handshake

Behaviour:
- Symbols, MSB-first, may straddle word boundaries:
  - '1' = one non-zero element, value taken from BPC stream.
  - '0' followed by ZRL_W bits r = r+1 zero elements.
- Reset values: cfg_rdy_o=1, idle_o=1; znz_rdy_o, bpc_rdy_o, vld_o, last_o, err_o, data_o all 0.
- Word buffer: word_q, bit pointer, word_vld_q, word_last_q.
  - znz_rdy_o = state in {FLAG, LEN, DRAIN} and (!word_vld_q or last bit consumed this cycle). Back-to-back words, no bubble.
- Exactly one bit consumed per cycle, only when the step completes.
- Element counter cnt_q: loaded from cfg_num_i; decrements on each vld_o&&rdy_i. last_o = vld_o && cnt_q==1.
- IDLE: cfg_rdy_o=1. On cfg handshake: load cnt_q, clear err_o. cfg_num_i==0 -> DRAIN; else -> FLAG.
- FLAG: needs word_vld_q.
  - Bit '1': vld_o = bpc_vld_i, data_o = bpc_data_i, bpc_rdy_o = rdy_i. On output handshake, consume bit and pop BPC (same cycle). If bpc_vld_i=0, stall with vld_o=0.
  - Bit '0': consume, clear run register, -> LEN. No output that cycle.
- LEN: consume one bit per cycle with word_vld_q, shifting into run_q MSB-first. After ZRL_W bits -> ZOUT.
- ZOUT: vld_o=1, data_o=0.
  - Each handshake decrements run_q.
  - After r+1 zeros -> FLAG.
  - If cnt_q hits 0 first: truncate the run and set err_o.
- Any state: handshake with cnt_q==1 -> DRAIN.
- DRAIN:
  - Discard the rest of the current word.
  - If that word had word_last_q, -> IDLE next cycle.
  - Otherwise accept and discard words until a znz_last_i handshake, then -> IDLE.
  - If no word is buffered and the last word was already consumed, -> IDLE immediately.
- Premature end: last bit of a word_last_q word consumed while cnt_q>0, or LEN incomplete -> set err_o, -> IDLE. No further outputs and no last_o.
- data_o/vld_o combinational from state/buffer/BPC inputs. rdy_i is never used to drive vld_o.
- Asynchronous reset mid-stream: all state, counters and buffer cleared immediately to reset values. Partial stream lost.
- Max throughput: 1 element/cycle for non-zeros and within zero runs. Each zero-run symbol costs 1+ZRL_W non-output cycles.

Optional Feature:
EBPC_ZNZ_DEC_ERR_EN.
- Defined: err_o driven as above.
- Undefined: err_o tied 0 and no error logic synthesised. Truncation and premature-end state transitions stay identical.

Test Plan:
- DATA_W=8, ZRL_W=4, cfg 5; word 8'b10001010 last; BPC 0x5A, 0x33 -> out 5A,00,00,00,33; last_o on 33; idle; err_o=0.
- cfg 23; words 8'b11111110, 8'b11110000(last); BPC 0x01..0x07 -> out 01..07 then 16 zeros (run straddles words); last_o on 23rd; err_o=0.
- Scenario 1 with rdy_i low 3 cycles during the zero run -> data_o=0, vld_o held, cnt_q frozen; identical sequence after release.
- Scenario 1 with bpc_vld_i low 4 cycles at first '1' -> vld_o=0, no bit consumed, bpc_rdy_o follows rdy_i; 5A emitted when valid.
- cfg 2; words 8'hFF (not last), 8'h00 (last) -> out 2 BPC values with last_o on 2nd; both words accepted and discarded; idle; err_o=0.
- cfg 10; word 8'b10000100 last -> out v,00,00; pad '0' starts LEN with no bits left -> err_o=1, no last_o, IDLE; next cfg handshake clears err_o.

Source files
------------

// File: rtl/ebpc_znz_decoder.sv
// EBPC zero/non-zero run-length decoder: expands the ZNZ symbol stream and merges BPC non-zero values.
// Optional macro EBPC_ZNZ_DEC_ERR_EN enables the sticky stream-format error flag err_o.
module ebpc_znz_decoder #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MAX_ZERO_RUN = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [CNT_W-1:0]  cfg_num_i,
    input  logic              cfg_vld_i,
    output logic              cfg_rdy_o,
    input  logic [DATA_W-1:0] znz_data_i,
    input  logic              znz_last_i,
    input  logic              znz_vld_i,
    output logic              znz_rdy_o,
    input  logic [DATA_W-1:0] bpc_data_i,
    input  logic              bpc_vld_i,
    output logic              bpc_rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              idle_o,
    output logic              err_o
);

    localparam int unsigned ZRL_W = $clog2(MAX_ZERO_RUN);
    localparam int unsigned PTR_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned LEN_W = (ZRL_W > 1) ? $clog2(ZRL_W) : 1;
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(DATA_W - 1);
    localparam logic [LEN_W-1:0] LEN_TOP = LEN_W'(ZRL_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLAG,
        S_LEN,
        S_ZOUT,
        S_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               word_vld_q, word_vld_d;
    logic               word_last_q, word_last_d;
    logic               last_seen_q, last_seen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ZRL_W-1:0]   run_q, run_d;
    logic [LEN_W-1:0]   len_q, len_d;

    logic cur_bit, cnt_is_one, cfg_hs, znz_hs, out_hs;
    logic consume, word_done, premature;

    assign cur_bit    = word_q[ptr_q];
    assign cnt_is_one = (cnt_q == CNT_W'(1));
    assign cfg_rdy_o  = (state_q == S_IDLE);
    assign idle_o     = (state_q == S_IDLE) && !word_vld_q;
    assign cfg_hs     = cfg_vld_i && cfg_rdy_o;
    assign znz_hs     = znz_vld_i && znz_rdy_o;
    assign out_hs     = vld_o && rdy_i;
    assign last_o     = vld_o && cnt_is_one;

    always_comb begin
        vld_o     = 1'b0;
        data_o    = '0;
        bpc_rdy_o = 1'b0;
        if (state_q == S_FLAG && word_vld_q && cur_bit) begin
            vld_o     = bpc_vld_i;
            data_o    = bpc_data_i;
            bpc_rdy_o = rdy_i;
        end else if (state_q == S_ZOUT) begin
            vld_o = 1'b1;
        end
    end

    always_comb begin
        consume = 1'b0;
        if (word_vld_q) begin
            if (state_q == S_FLAG) begin
                consume = cur_bit ? out_hs : 1'b1;
            end else if (state_q == S_LEN) begin
                consume = 1'b1;
            end
        end
    end

    assign word_done = consume && (ptr_q == '0);
    // Running out of a final word is only legal when the same handshake finishes the element count.
    assign premature = word_done && word_last_q && !(out_hs && cnt_is_one);

    // A final word is never followed by an accept: the next word belongs to the next stream.
    always_comb begin
        znz_rdy_o = 1'b0;
        case (state_q)
            S_FLAG, S_LEN: znz_rdy_o = (!word_vld_q && !last_seen_q) || (word_done && !word_last_q);
            S_DRAIN:       znz_rdy_o = word_vld_q ? !word_last_q : !last_seen_q;
            default:       znz_rdy_o = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        ptr_d       = ptr_q;
        word_vld_d  = word_vld_q;
        word_last_d = word_last_q;
        last_seen_d = last_seen_q | (znz_hs & znz_last_i);
        cnt_d       = cnt_q;
        run_d       = run_q;
        len_d       = len_q;

        if (cfg_hs) begin
            cnt_d       = cfg_num_i;
            last_seen_d = 1'b0;
        end else if (out_hs) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (consume) begin
            if (word_done) begin
                word_vld_d = 1'b0;
            end else begin
                ptr_d = ptr_q - PTR_W'(1);
            end
        end

        if (znz_hs && (state_q == S_FLAG || state_q == S_LEN)) begin
            word_d      = znz_data_i;
            ptr_d       = PTR_TOP;
            word_vld_d  = 1'b1;
            word_last_d = znz_last_i;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_hs) begin
                    state_d = (cfg_num_i == '0) ? S_DRAIN : S_FLAG;
                end
            end
            S_FLAG: begin
                if (consume) begin
                    if (cur_bit) begin
                        if (cnt_is_one) begin
                            state_d = S_DRAIN;
                        end else if (premature) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        run_d   = '0;
                        len_d   = '0;
                        state_d = premature ? S_IDLE : S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (consume) begin
                    run_d = (run_q << 1) | ZRL_W'(cur_bit);
                    len_d = len_q + LEN_W'(1);
                    if (premature) begin
                        state_d = S_IDLE;
                    end else if (len_q == LEN_TOP) begin
                        state_d = S_ZOUT;
                    end
                end
            end
            S_ZOUT: begin
                if (out_hs) begin
                    run_d = run_q - ZRL_W'(1);
                    if (cnt_is_one) begin
                        state_d = S_DRAIN;
                    end else if (run_q == '0) begin
                        state_d = S_FLAG;
                    end
                end
            end
            S_DRAIN: begin
                word_vld_d = 1'b0;
                if ((word_vld_q && word_last_q) || (!word_vld_q && last_seen_q) ||
                    (znz_hs && znz_last_i)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            ptr_q       <= '0;
            word_vld_q  <= 1'b0;
            word_last_q <= 1'b0;
            last_seen_q <= 1'b0;
            cnt_q       <= '0;
            run_q       <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            ptr_q       <= ptr_d;
            word_vld_q  <= word_vld_d;
            word_last_q <= word_last_d;
            last_seen_q <= last_seen_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            len_q       <= len_d;
        end
    end

`ifdef EBPC_ZNZ_DEC_ERR_EN
    logic err_q, err_d, trunc;

    always_comb begin
        trunc = (state_q == S_ZOUT) && out_hs && cnt_is_one && (run_q != '0);
        err_d = err_q;
        if (cfg_hs) begin
            err_d = 1'b0;
        end else if (premature || trunc) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ebpc_znz_decoder.sv
// Table-driven bench for ebpc_znz_decoder: whole-stream vectors plus reset and error-clear sequences.
module tb_ebpc_znz_decoder;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
`ifdef EBPC_ZNZ_DEC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [CNT_W-1:0]  cfg_num_i = '0;
    logic              cfg_vld_i = 1'b0;
    logic              cfg_rdy_o;
    logic [DATA_W-1:0] znz_data_i = '0;
    logic              znz_last_i = 1'b0;
    logic              znz_vld_i = 1'b0;
    logic              znz_rdy_o;
    logic [DATA_W-1:0] bpc_data_i = '0;
    logic              bpc_vld_i = 1'b0;
    logic              bpc_rdy_o;
    logic [DATA_W-1:0] data_o;
    logic              last_o;
    logic              vld_o;
    logic              rdy_i = 1'b1;
    logic              idle_o;
    logic              err_o;

    ebpc_znz_decoder #(
        .DATA_W      (DATA_W),
        .MAX_ZERO_RUN(16),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .cfg_num_i (cfg_num_i),
        .cfg_vld_i (cfg_vld_i),
        .cfg_rdy_o (cfg_rdy_o),
        .znz_data_i(znz_data_i),
        .znz_last_i(znz_last_i),
        .znz_vld_i (znz_vld_i),
        .znz_rdy_o (znz_rdy_o),
        .bpc_data_i(bpc_data_i),
        .bpc_vld_i (bpc_vld_i),
        .bpc_rdy_o (bpc_rdy_o),
        .data_o    (data_o),
        .last_o    (last_o),
        .vld_o     (vld_o),
        .rdy_i     (rdy_i),
        .idle_o    (idle_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0]      cfg;
        int               nw;
        logic [1:0][7:0]  w;
        int               nb;
        logic [7:0][7:0]  bpc;
        int               n;
        logic [23:0][7:0] exp_d;
        bit               exp_last;
        bit               exp_err;
        int               rdy_at;
        int               rdy_len;
        int               bpc_at;
        int               bpc_len;
    } vec_t;

    vec_t tv[9];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic run_case(input int ci);
        vec_t v;
        int   k, wi, bi, bst, rsc, t;
        bit   done, bstall, rstall;
        v = tv[ci];
        k = 0; wi = 0; bi = 0; bst = 0; rsc = 0; t = 0; done = 1'b0;
        while (!cfg_rdy_o && t < 20) begin
            @(posedge clk_i); #1;
            t++;
        end
        chk($sformatf("case%0d cfg_rdy", ci), cfg_rdy_o, 1);
        cfg_num_i = v.cfg;
        cfg_vld_i = 1'b1;
        @(posedge clk_i); #1;
        cfg_vld_i = 1'b0;
        chk($sformatf("case%0d err_after_cfg", ci), err_o, 0);
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            znz_vld_i  = (wi < v.nw);
            znz_data_i = v.w[wi < 2 ? wi : 0];
            znz_last_i = (wi == v.nw - 1);
            bstall     = (bi == v.bpc_at) && (bst < v.bpc_len);
            rstall     = (k == v.rdy_at) && (rsc < v.rdy_len);
            bpc_vld_i  = (bi < v.nb) && !bstall;
            bpc_data_i = v.bpc[bi < 8 ? bi : 0];
            rdy_i      = rstall ? 1'b0 : (bstall ? bst[0] : 1'b1);
            @(negedge clk_i);
            if (cfg_rdy_o) begin
                done = 1'b1;
                znz_vld_i = 1'b0;
                bpc_vld_i = 1'b0;
                rdy_i     = 1'b1;
            end else begin
                if (bstall) begin
                    chk($sformatf("case%0d bpc_stall vld", ci), vld_o, 0);
                    chk($sformatf("case%0d bpc_stall bpc_rdy", ci), bpc_rdy_o, rdy_i);
                    bst++;
                end
                if (rstall) begin
                    chk($sformatf("case%0d rdy_stall vld", ci), vld_o, 1);
                    chk($sformatf("case%0d rdy_stall data", ci), data_o, v.exp_d[k < 24 ? k : 0]);
                    rsc++;
                end
                if (vld_o && rdy_i) begin
                    if (k < v.n) begin
                        chk($sformatf("case%0d out%0d data", ci, k), data_o, v.exp_d[k]);
                        chk($sformatf("case%0d out%0d last", ci, k), last_o,
                            (v.exp_last && k == v.n - 1));
                    end else begin
                        chk($sformatf("case%0d extra_output", ci), k, v.n - 1);
                    end
                    k++;
                end
                if (znz_vld_i && znz_rdy_o) wi++;
                if (bpc_vld_i && bpc_rdy_o) bi++;
            end
            @(posedge clk_i); #1;
        end
        chk($sformatf("case%0d reached_idle", ci), done, 1);
        chk($sformatf("case%0d out_count", ci), k, v.n);
        chk($sformatf("case%0d words_accepted", ci), wi, v.nw);
        chk($sformatf("case%0d bpc_popped", ci), bi, v.nb);
        chk($sformatf("case%0d idle_o", ci), idle_o, 1);
        chk($sformatf("case%0d vld_in_idle", ci), vld_o, 0);
        chk($sformatf("case%0d err_o", ci), err_o, v.exp_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 9; i++) begin
            tv[i].cfg = '0; tv[i].nw = 0; tv[i].w = '0; tv[i].nb = 0; tv[i].bpc = '0;
            tv[i].n = 0; tv[i].exp_d = '0; tv[i].exp_last = 1'b1; tv[i].exp_err = 1'b0;
            tv[i].rdy_at = 255; tv[i].rdy_len = 0; tv[i].bpc_at = 255; tv[i].bpc_len = 0;
        end
        // 0: 1 | 0 0010 | 1 | pad -> 5A 00 00 00 33
        tv[0].cfg = 16'd5; tv[0].nw = 1; tv[0].w[0] = 8'b10001010;
        tv[0].nb = 2; tv[0].bpc[0] = 8'h5A; tv[0].bpc[1] = 8'h33;
        tv[0].n = 5; tv[0].exp_d[0] = 8'h5A; tv[0].exp_d[4] = 8'h33;
        // 1: seven non-zeros, then a 16-zero run whose length field straddles the word boundary
        tv[1].cfg = 16'd23; tv[1].nw = 2; tv[1].w[0] = 8'b11111110; tv[1].w[1] = 8'b11110000;
        tv[1].nb = 7; tv[1].n = 23;
        for (int i = 0; i < 7; i++) begin
            tv[1].bpc[i]   = 8'(i + 1);
            tv[1].exp_d[i] = 8'(i + 1);
        end
        tv[2] = tv[0]; tv[2].rdy_at = 2; tv[2].rdy_len = 3;
        tv[3] = tv[0]; tv[3].bpc_at = 0; tv[3].bpc_len = 4;
        tv[4].cfg = 16'd2; tv[4].nw = 2; tv[4].w[0] = 8'hFF; tv[4].w[1] = 8'h00;
        tv[4].nb = 2; tv[4].bpc[0] = 8'hA1; tv[4].bpc[1] = 8'hB2;
        tv[4].n = 2; tv[4].exp_d[0] = 8'hA1; tv[4].exp_d[1] = 8'hB2;
        // 5: stream ends inside a length field with elements still owed
        tv[5].cfg = 16'd10; tv[5].nw = 1; tv[5].w[0] = 8'b10000100;
        tv[5].nb = 1; tv[5].bpc[0] = 8'hC3; tv[5].n = 3; tv[5].exp_d[0] = 8'hC3;
        tv[5].exp_last = 1'b0; tv[5].exp_err = ERR_EN;
        tv[6] = tv[0];
        tv[7].cfg = 16'd0; tv[7].nw = 2; tv[7].w[0] = 8'h55; tv[7].w[1] = 8'h12;
        tv[8] = tv[0];

        #3;
        chk("reset cfg_rdy_o", cfg_rdy_o, 1);
        chk("reset idle_o", idle_o, 1);
        chk("reset znz_rdy_o", znz_rdy_o, 0);
        chk("reset bpc_rdy_o", bpc_rdy_o, 0);
        chk("reset vld_o", vld_o, 0);
        chk("reset last_o", last_o, 0);
        chk("reset err_o", err_o, 0);
        chk("reset data_o", data_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 8; i++) run_case(i);

        // Asynchronous reset in the middle of a stream.
        cfg_num_i = 16'd23; cfg_vld_i = 1'b1;
        @(posedge clk_i); #1;
        cfg_vld_i = 1'b0;
        znz_vld_i = 1'b1; znz_data_i = 8'hFE; znz_last_i = 1'b0;
        bpc_vld_i = 1'b1; bpc_data_i = 8'h01; rdy_i = 1'b1;
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        chk("midreset pre vld_o", vld_o, 1);
        chk("midreset pre cfg_rdy_o", cfg_rdy_o, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midreset vld_o", vld_o, 0);
        chk("midreset cfg_rdy_o", cfg_rdy_o, 1);
        chk("midreset idle_o", idle_o, 1);
        chk("midreset znz_rdy_o", znz_rdy_o, 0);
        chk("midreset bpc_rdy_o", bpc_rdy_o, 0);
        znz_vld_i = 1'b0; bpc_vld_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run_case(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
